// File: rtl/wb_fetch_unpack_pkg.sv
// Shared types and constants for the wb_fetch prefetch/unpack block.
package wb_fetch_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RECV  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Cycles allowed in ISSUE for wb_fetch to drop ready before giving up.
    localparam int ISSUE_TIMEOUT = 4;
    localparam int TMR_BITS      = 3;

    // Number of byte lanes in a fetched word.
    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/wb_fetch_unpack_fifo_sync.sv
// Single-clock word FIFO. Full/empty come from the occupancy count; the
// pointers simply wrap modulo DEPTH. The head word is read straight out of
// the storage registers so the consumer can load it on the pop edge.
module wb_fetch_unpack_fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int DBITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [DBITS:0]   level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DBITS-1:0] wr_ptr;
    logic [DBITS-1:0] rd_ptr;
    logic [DBITS:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (level_q == (DBITS+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign level_o   = level_q;
    assign rd_data_o = mem[rd_ptr];

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wr_data_i;
    end

    // Pointer and occupancy bookkeeping; push and pop together leave level unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_fetch_unpack.sv
// Snoops wb_fetch read responses into a word FIFO, prefetches whole blocks
// while there is room, and streams the words out as little-endian bytes.
//
//   state | meaning
//   IDLE  | no block outstanding; issue one when enabled, wb_fetch ready, room
//   ISSUE | fetch pulsed; waiting for wb_fetch to drop ready (timeout -> IDLE)
//   RECV  | counting captured acks until the whole block has arrived
//   DONE  | block received; waiting for wb_fetch to return to ready
module wb_fetch_unpack
    import wb_fetch_unpack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FETCH = 8,
    parameter int FBITS = 3,
    parameter int DEPTH = 16,
    parameter int DBITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    output logic             fetch_o,
    input  logic             ready_i,
    input  logic             cyc_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             valid_o,
    input  logic             next_i,
    output logic [7:0]       byte_o,
    output logic [DBITS:0]   level_o,
    output logic             busy_o,
    output logic             oflow_o
);

    localparam int                 LANES      = byte_lanes(WIDTH);
    localparam int                 IBITS      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [DBITS+1:0]   ROOM_LIMIT = (DBITS+2)'(DEPTH - FETCH);
    localparam logic [FBITS:0]     BEATS      = (FBITS+1)'(FETCH);
    localparam logic [IBITS-1:0]   LAST_IDX   = IBITS'(LANES - 1);

    state_t                state_q, state_d;
    logic                  issue;
    logic [TMR_BITS-1:0]   tmr_q;
    logic [FBITS:0]        beat_q;
    logic                  fetch_q;
    logic                  oflow_q;
    logic                  ack_cap;
    logic                  beats_done;
    logic                  room;
    logic [DBITS+1:0]      committed;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DBITS:0]        level;
    logic [WIDTH-1:0]      head;
    logic [WIDTH-1:0]      ser_word;
    logic [IBITS-1:0]      ser_idx;
    logic                  ser_valid;
    logic                  take;
    logic                  take_last;

    assign busy_o     = (state_q != ST_IDLE);
    assign ack_cap    = cyc_i && ack_i && busy_o;
    // The word held by the serializer still counts against free space.
    assign committed  = {1'b0, level} + {{(DBITS+1){1'b0}}, ser_valid};
    assign room       = (committed <= ROOM_LIMIT);
    assign beats_done = (beat_q >= BEATS) || (ack_cap && (beat_q == BEATS - 1'b1));

    wb_fetch_unpack_fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DBITS (DBITS)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (ack_cap),
        .wr_data_i (dat_i),
        .pop_i     (fifo_pop),
        .rd_data_o (head),
        .level_o   (level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Block sequencing: next state and the issue strobe.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && ready_i && room) begin
                    state_d = ST_ISSUE;
                    issue   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!ready_i)           state_d = ST_RECV;
                else if (tmr_q == '0)   state_d = ST_IDLE;
            end
            ST_RECV: begin
                if (beats_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, issue timeout down-counter, beat counter and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            beat_q  <= '0;
            fetch_q <= 1'b0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= issue;
            if (issue)                                   tmr_q <= TMR_BITS'(ISSUE_TIMEOUT - 1);
            else if (state_q == ST_ISSUE && tmr_q != '0) tmr_q <= tmr_q - 1'b1;
            if (issue)        beat_q <= '0;
            else if (ack_cap) beat_q <= beat_q + 1'b1;
            if (ack_cap && fifo_full) oflow_q <= 1'b1;
        end
    end

    assign take      = ser_valid && next_i;
    assign take_last = take && (ser_idx == LAST_IDX);
    // Refill on the same edge the last byte leaves, so the stream has no bubble.
    assign fifo_pop  = !fifo_empty && (!ser_valid || take_last);

    // Serializer: one word plus the index of the byte currently presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ser_word  <= '0;
            ser_idx   <= '0;
            ser_valid <= 1'b0;
        end else if (fifo_pop) begin
            ser_word  <= head;
            ser_idx   <= '0;
            ser_valid <= 1'b1;
        end else if (take_last) begin
            ser_valid <= 1'b0;
        end else if (take) begin
            ser_idx <= ser_idx + 1'b1;
        end
    end

    assign byte_o  = ser_word[{ser_idx, 3'b000} +: 8];
    assign valid_o = ser_valid;
    assign fetch_o = fetch_q;
    assign level_o = level;
    assign oflow_o = oflow_q;

endmodule
